// File: rtl/poca_pkg.sv
// Shared types and default widths for the POCA measurement sequencer.
package poca_pkg;

  localparam int CW_DEF = 32;
  localparam int RW_DEF = 24;
  localparam int NW_DEF = 8;
  localparam int AW_DEF = 40;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    OUT     = 3'd5
  } poca_state_t;

endpackage

// File: rtl/poca_sat_acc.sv
// Saturating accumulator: sums zero-extended RO counts, clamps at all ones and latches ovf.
module poca_sat_acc
  import poca_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          add,
  input  logic [RW-1:0] din,
  output logic [AW-1:0] acc,
  output logic          ovf
);

  logic [AW:0] sum;

  assign sum = {1'b0, acc} + {{(AW + 1 - RW){1'b0}}, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add) begin
      if (sum[AW]) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[AW-1:0];
      end
    end
  end

endmodule

// File: rtl/poca_meas_ctrl.sv
// Measurement sequencer driving the POCA down-counter and RO counter over repeated windows.
// IDLE: wait for req | CLEAR: reset counters | LOAD: load window | RUN: window open | CAPTURE: accumulate | OUT: result handshake
module poca_meas_ctrl
  import poca_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int RW = RW_DEF,
  parameter int NW = NW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [CW-1:0] cycle_in,
  input  logic [NW-1:0] num_meas,
  input  logic          abort,
  output logic          busy,
  output logic          err,
  output logic          cnt_rst,
  output logic          cnt_load,
  output logic [CW-1:0] cnt_cycle,
  output logic          start_cnt,
  input  logic          cnt_done,
  output logic          ro_clr,
  output logic          ro_en,
  input  logic [RW-1:0] ro_cnt,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_data,
  output logic          res_ovf
);

  localparam logic [NW-1:0] REM_ONE = NW'(1);

  poca_state_t   state, state_nxt;
  logic [CW-1:0] cyc_q;
  logic [NW-1:0] rem;
  logic          aborting;
  logic          accept;
  logic          do_abort;

  assign accept   = (state == IDLE) && req && (cycle_in != '0);
  assign do_abort = (state != IDLE) && abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cyc_q    <= '0;
      rem      <= '0;
      aborting <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state == IDLE) && req && (cycle_in == '0);
      if (accept) begin
        cyc_q <= cycle_in;
        rem   <= (num_meas == '0) ? REM_ONE : num_meas;
      end else if ((state == CAPTURE) && !abort) begin
        rem <= rem - REM_ONE;
      end
      // The abort flag steers the single CLEAR pass back to IDLE instead of LOAD.
      if (do_abort)
        aborting <= 1'b1;
      else if (state == CLEAR)
        aborting <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLEAR;
      CLEAR:   state_nxt = aborting ? IDLE : LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt_done) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (rem > REM_ONE) ? CLEAR : OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (do_abort)
      state_nxt = CLEAR;
  end

  always_comb begin
    busy      = (state != IDLE);
    cnt_rst   = (state == CLEAR);
    ro_clr    = (state == CLEAR);
    cnt_load  = (state == LOAD);
    start_cnt = (state == RUN);
    ro_en     = (state == RUN);
    res_valid = (state == OUT);
  end

  assign cnt_cycle = cyc_q;

  poca_sat_acc #(
    .RW(RW),
    .AW(AW)
  ) u_acc (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .add((state == CAPTURE) && !abort),
    .din(ro_cnt),
    .acc(res_data),
    .ovf(res_ovf)
  );

endmodule

// File: tb/tb_poca_meas_ctrl.sv
// Randomized bench for poca_meas_ctrl: a 40-bit and a 24-bit accumulator instance share stimulus and counter model.
module tb_poca_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] cycle_in;
  logic [7:0]  num_meas;
  logic        abort;
  logic        res_ready;
  logic [23:0] ro_cnt;
  logic        cnt_done;

  logic        busy, err, cnt_rst, cnt_load, start_cnt, ro_clr, ro_en, res_valid, res_ovf;
  logic [31:0] cnt_cycle;
  logic [39:0] res_data;

  logic        busy_s, err_s, cnt_rst_s, cnt_load_s, start_cnt_s, ro_clr_s, ro_en_s, res_valid_s, res_ovf_s;
  logic [31:0] cnt_cycle_s;
  logic [23:0] res_data_s;

  int n_chk = 0;
  int n_err = 0;
  int unsigned ro_plan[$];

  always #5 clk = ~clk;

  poca_meas_ctrl #(.CW(32), .RW(24), .NW(8), .AW(40)) dut (
    .clk(clk), .rst(rst), .req(req), .cycle_in(cycle_in), .num_meas(num_meas), .abort(abort),
    .busy(busy), .err(err), .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_cycle(cnt_cycle),
    .start_cnt(start_cnt), .cnt_done(cnt_done), .ro_clr(ro_clr), .ro_en(ro_en), .ro_cnt(ro_cnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf)
  );

  poca_meas_ctrl #(.CW(32), .RW(24), .NW(8), .AW(24)) dut_s (
    .clk(clk), .rst(rst), .req(req), .cycle_in(cycle_in), .num_meas(num_meas), .abort(abort),
    .busy(busy_s), .err(err_s), .cnt_rst(cnt_rst_s), .cnt_load(cnt_load_s), .cnt_cycle(cnt_cycle_s),
    .start_cnt(start_cnt_s), .cnt_done(cnt_done), .ro_clr(ro_clr_s), .ro_en(ro_en_s), .ro_cnt(ro_cnt),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s), .res_ovf(res_ovf_s)
  );

  // Behavioural POCA down-counter: done sets on the edge where the count is 1, sticky until cnt_rst.
  logic [31:0] tc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc <= '0; cnt_done <= 1'b0;
    end else if (cnt_rst) begin
      tc <= '0; cnt_done <= 1'b0;
    end else if (cnt_load) begin
      tc <= cnt_cycle;
    end else if (start_cnt && !cnt_done && tc != 0) begin
      tc <= tc - 1;
      if (tc == 1) cnt_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {busy, err, cnt_rst, cnt_load, start_cnt, ro_clr, ro_en, res_valid, res_ovf,
            |cnt_cycle, |res_data, busy_s, err_s, cnt_rst_s, cnt_load_s, start_cnt_s,
            ro_clr_s, ro_en_s, res_valid_s, res_ovf_s, |cnt_cycle_s, |res_data_s};
  endfunction

  // One full request: windows, RO sum, saturation in both widths, then the result handshake.
  task automatic do_meas(input logic [31:0] cyc, input logic [7:0] nm, input int hold, input bit ab_req);
    int wins = (nm == 0) ? 1 : int'(nm);
    longint unsigned sum = 0;
    longint unsigned exp_a, exp_s;
    int loads = 0, clrs = 0, run_len = 0, budget;
    bit prev_rst = 0, prev_load = 0;
    int unsigned v;
    req = 1'b1; cycle_in = cyc; num_meas = nm; abort = ab_req;
    @(negedge clk);
    req = 1'b0; abort = 1'b0;
    chk("accept_busy", {busy, busy_s}, 2'b11);
    budget = wins * (int'(cyc) + 8) + 20;
    while (!res_valid && budget > 0) begin
      if (cnt_rst) clrs++;
      if (cnt_load) begin
        loads++;
        chk("load_after_clr", prev_rst, 1);
        chk("cnt_cycle", cnt_cycle, cyc);
        v = (ro_plan.size() != 0) ? ro_plan.pop_front() : ($urandom & 32'hFF_FFFF);
        ro_cnt = v[23:0];
        sum += v;
      end
      if (ro_en) begin
        if (run_len == 0) chk("run_after_load", prev_load, 1);
        chk("start_cnt", start_cnt, 1);
        run_len++;
      end else if (run_len != 0) begin
        chk("run_len", run_len, cyc + 1);
        run_len = 0;
      end
      prev_rst = cnt_rst; prev_load = cnt_load;
      @(negedge clk);
      budget--;
    end
    chk("no_timeout", budget > 0, 1);
    chk("windows_load", loads, wins);
    chk("windows_clr", clrs, wins);
    exp_a = (sum > 64'hFF_FFFF_FFFF) ? 64'hFF_FFFF_FFFF : sum;
    exp_s = (sum > 64'hFF_FFFF) ? 64'hFF_FFFF : sum;
    chk("res_valid", {res_valid, res_valid_s}, 2'b11);
    chk("res_data", res_data, exp_a);
    chk("res_ovf", res_ovf, sum > 64'hFF_FFFF_FFFF);
    chk("res_data24", res_data_s, exp_s);
    chk("res_ovf24", res_ovf_s, sum > 64'hFF_FFFF);
    for (int i = 0; i < hold; i++) begin
      req = (i == 0); cycle_in = 32'd7; num_meas = 8'd1;
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_a);
      chk("hold_data24", res_data_s, exp_s);
    end
    req = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_valid", res_valid, 0);
    chk("done_busy", {busy, busy_s}, 2'b00);
  endtask

  initial begin
    int b;
    rst = 1'b1; req = 1'b0; cycle_in = '0; num_meas = '0; abort = 1'b0; res_ready = 1'b0; ro_cnt = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", all_outs(), 0);

    ro_plan.push_back(100);
    do_meas(32'd5, 8'd1, 0, 1'b0);

    ro_plan = {10, 20, 30, 40};
    do_meas(32'd3, 8'd4, 0, 1'b0);

    req = 1'b1; cycle_in = '0; num_meas = 8'd3;
    @(negedge clk);
    req = 1'b0;
    chk("err_pulse", {err, err_s}, 2'b11);
    chk("err_busy", busy, 0);
    chk("err_load", cnt_load, 0);
    @(negedge clk);
    chk("err_once", err, 0);
    chk("err_idle", {busy, cnt_load, cnt_rst}, 3'b000);

    ro_plan = {32'hFF_FFF0, 32'hFF_FFF0};
    do_meas(32'd2, 8'd2, 0, 1'b0);

    req = 1'b1; cycle_in = 32'd6; num_meas = 8'd2;
    @(negedge clk);
    req = 1'b0;
    b = 0;
    while (!ro_en && b < 20) begin @(negedge clk); b++; end
    chk("abort_reach_run", ro_en, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_clear", {cnt_rst, ro_clr, busy}, 3'b111);
    @(negedge clk);
    chk("abort_idle", {busy, cnt_rst, res_valid}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_novalid", {res_valid, res_valid_s, busy}, 3'b000);
    end
    do_meas(32'd4, 8'd2, 0, 1'b0);

    do_meas(32'd3, 8'd1, 10, 1'b0);

    do_meas(32'd2, 8'd0, 0, 1'b1);

    for (int t = 0; t < 8; t++)
      do_meas($urandom_range(8, 1), 8'($urandom_range(5, 0)), $urandom_range(3, 0), 1'b0);

    req = 1'b1; cycle_in = 32'd20; num_meas = 8'd1;
    @(negedge clk);
    req = 1'b0;
    b = 0;
    while (!ro_en && b < 20) begin @(negedge clk); b++; end
    repeat (3) @(negedge clk);
    chk("mid_run", ro_en, 1);
    #1 rst = 1'b1;
    #1 chk("async_rst_outs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {busy, res_valid}, 2'b00);
    end
    do_meas(32'd3, 8'd2, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/poca_meas_ctrl.md
Name: poca_meas_ctrl

Overview:
Measurement sequencer directly upstream of the POCA down-counter.
- Accepts a measurement request: window length in clock cycles, and the number of repeated windows.
- For each window it clears the counter, loads it, drives start_cnt, gates the ring-oscillator counter enable while the window is open, and waits for cnt_done.
- Accumulates the captured RO counts over all windows and returns the sum over a valid/ready handshake to the authentication datapath.

Parameters:
- CW, 32, cycle-count width; matches counter cycle input.
- RW, 24, ring-oscillator count width.
- NW, 8, repeat-count width.
- AW, 40, accumulator/result width; AW >= RW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  1  start request; sampled only in IDLE
- cycle_in  in  CW  window length for this request
- num_meas  in  NW  windows to run; 0 treated as 1
- abort  in  1  synchronous abort, any state
- busy  out  1  request accepted, result not yet consumed
- err  out  1  cycle_in==0 rejected; one-cycle pulse
- cnt_rst  out  1  to counter rst
- cnt_load  out  1  to counter cnt_load
- cnt_cycle  out  CW  to counter cycle
- start_cnt  out  1  to counter start_cnt
- cnt_done  in  1  from counter; sticky until cnt_rst
- ro_clr  out  1  clear RO counter
- ro_en  out  1  RO counter enable
- ro_cnt  in  RW  RO counter value
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  AW  accumulated RO count
- res_ovf  out  1  accumulator saturated

Behaviour:
- Reset: state=IDLE. All outputs are 0, including res_data and cnt_cycle. Internal registers are cleared. Reset mid-operation drops any run immediately; no result is produced.
- FSM states: IDLE, CLEAR, LOAD, RUN, CAPTURE, OUT. All control outputs are Moore-decoded from the state register.
- IDLE:
  - req=1 and cycle_in!=0: latch cycle_in and max(num_meas,1) into rem. Clear acc and ovf. Go to CLEAR.
  - req=1 and cycle_in==0: err pulses for one cycle; stay in IDLE. Rationale: the counter would wrap and never finish.
- CLEAR (1 cycle): cnt_rst=1, ro_clr=1. Go to LOAD.
- LOAD (1 cycle): cnt_load=1. cnt_cycle carries the latched value and holds it until the next accept. Go to RUN.
- RUN: start_cnt=1, ro_en=1. Leave on the first cycle cnt_done=1 is sampled, then go to CAPTURE.
  - The counter sets cnt_done on the edge where cnt==1, so RUN lasts exactly cycle+1 clock cycles.
  - ro_en is high for exactly those cycles.
- CAPTURE (1 cycle): ro_en=0, start_cnt=0; the RO value is stable.
  - At the exit edge: acc <= acc + ro_cnt, zero-extended.
  - If the sum exceeds 2^AW-1: acc <= all ones, ovf <= 1. Saturation persists through later windows.
  - rem <= rem-1. If rem was >1, go to CLEAR; else go to OUT.
- OUT: res_valid=1; res_data=acc and res_ovf=ovf, both stable while valid. On res_valid&&res_ready, go to IDLE. res_valid drops the next cycle and the handshake completes at the same edge.
- busy=1 in every state except IDLE; it falls with the completing handshake.
- abort=1 in any non-IDLE state: go to CLEAR with an abort flag set. CLEAR then returns to IDLE, giving one cycle of cnt_rst/ro_clr. res_valid is never raised for an aborted run. abort has priority over res_ready in OUT.
- req while busy is ignored; requests are not queued.
- Simultaneous req and abort in IDLE: abort has no effect and req is honoured.
- Repeat count wrap: rem counts down from the latched value; NW=8 allows 255 windows maximum.

Decomposition:
- Shared package poca_pkg holds:
  - state enum (IDLE..OUT, 3-bit encoding);
  - default width constants CW/RW/NW/AW.
- One natural sub-module: poca_sat_acc, the saturating AW-bit accumulator with clear and ovf flag.
- FSM and handshake stay in the top.

Test Plan:
- cycle_in=5, num_meas=1, ro_cnt driven at 100:
  - exact sequence is cnt_rst 1 cycle, cnt_load 1 cycle, then start_cnt/ro_en high 6 cycles;
  - then res_valid=1 with res_data=100 and res_ovf=0.
- cycle_in=3, num_meas=4, ro_cnt = 10, 20, 30, 40 per window -> four CLEAR/LOAD/RUN passes, then res_data=100.
- req with cycle_in=0 -> err is a one-cycle pulse; busy stays 0; no cnt_load.
- AW=24, RW=24, ro_cnt=0xFFFFF0, num_meas=2 -> res_data=0xFFFFFF, res_ovf=1.
- abort asserted in the 2nd RUN cycle:
  - next cycle CLEAR (cnt_rst=1), then IDLE with busy=0;
  - res_valid is never asserted;
  - a following req completes normally.
- Hold res_ready=0 for 10 cycles in OUT -> res_valid and res_data stable and a new req ignored. Then res_ready=1 -> IDLE next cycle. Async rst asserted mid-RUN clears all outputs immediately.
